// File: rtl/sram_req_ctrl.sv
// Request front-end for a single-port SRAM with one-cycle read latency.
// Reads are credited against a small response FIFO so a stalled consumer never loses data.
module sram_req_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_W/8-1:0]   req_wmask_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [DATA_W/8-1:0]   sram_wmask_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wr_data_o,
  input  logic [DATA_W-1:0]     sram_rd_data_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 2);

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_pending;
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [CNT_W-1:0]  credits_used;
  logic              accept;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // A read in flight already owns a FIFO slot; pops only return credit once registered.
  assign credits_used = count + CNT_W'(rd_pending);
  assign req_ready_o  = rst_n & (credits_used < CNT_W'(RSP_DEPTH));
  assign accept       = req_valid_i & req_ready_o;
  assign push         = rd_pending;
  assign rsp_valid_o  = (count != '0);
  assign pop          = rsp_valid_o & rsp_ready_i;

  assign sram_cs_o      = accept;
  assign sram_we_o      = accept & req_we_i;
  assign sram_wmask_o   = (accept & req_we_i) ? req_wmask_i : '0;
  assign sram_addr_o    = accept ? req_addr_i : '0;
  assign sram_wr_data_o = accept ? req_wdata_i : '0;

  // Stage boundary: command accepted -> SRAM data returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      rd_pending <= accept & ~req_we_i;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage boundary: SRAM data captured into response storage
  always_ff @(posedge clk) begin
    if (push) rsp_mem[wr_ptr] <= sram_rd_data_i;
  end

  assign rsp_rdata_o = rsp_valid_o ? rsp_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_sram_req_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0]  req_wmask = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        sram_cs, sram_we;
  logic [3:0]  sram_wmask;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wr_data, sram_rd_data = '0;

  logic        s3_req_valid = 1'b0, s3_req_ready;
  logic [7:0]  s3_req_addr = '0;
  logic        s3_rsp_valid, s3_rsp_ready = 1'b1;
  logic [31:0] s3_rsp_rdata;
  logic        s3_sram_cs, s3_sram_we;
  logic [3:0]  s3_sram_wmask;
  logic [7:0]  s3_sram_addr;
  logic [31:0] s3_sram_wr_data, s3_sram_rd_data = '0;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(8), .DATA_W(32), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_wmask_i(req_wmask), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_wmask_o(sram_wmask),
    .sram_addr_o(sram_addr), .sram_wr_data_o(sram_wr_data), .sram_rd_data_i(sram_rd_data)
  );

  sram_req_ctrl #(.ADDR_W(8), .DATA_W(32), .RSP_DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(s3_req_valid), .req_ready_o(s3_req_ready), .req_we_i(1'b0),
    .req_wmask_i(4'h0), .req_addr_i(s3_req_addr), .req_wdata_i(32'h0),
    .rsp_valid_o(s3_rsp_valid), .rsp_ready_i(s3_rsp_ready), .rsp_rdata_o(s3_rsp_rdata),
    .sram_cs_o(s3_sram_cs), .sram_we_o(s3_sram_we), .sram_wmask_o(s3_sram_wmask),
    .sram_addr_o(s3_sram_addr), .sram_wr_data_o(s3_sram_wr_data), .sram_rd_data_i(s3_sram_rd_data)
  );

  // Behavioural SRAMs: bus sampled mid-cycle, acted on at the clock edge.
  logic [31:0] sram_mem [256];
  logic        b_cs, b_we, b3_rd;
  logic [3:0]  b_mask;
  logic [7:0]  b_addr, b3_addr;
  logic [31:0] b_wdata;

  // Reference model inputs sampled mid-cycle
  logic        s_acc, s_we, s_pop;
  logic [3:0]  s_mask;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;

  always @(negedge clk) begin
    b_cs    <= sram_cs;
    b_we    <= sram_we;
    b_mask  <= sram_wmask;
    b_addr  <= sram_addr;
    b_wdata <= sram_wr_data;
    b3_rd   <= s3_sram_cs && !s3_sram_we;
    b3_addr <= s3_sram_addr;
    s_acc   <= req_valid && req_ready;
    s_we    <= req_we;
    s_mask  <= req_wmask;
    s_addr  <= req_addr;
    s_wdata <= req_wdata;
    s_pop   <= rsp_valid && rsp_ready;
  end

  always @(posedge clk) begin
    if (b_cs && b_we)
      for (int b = 0; b < 4; b++)
        if (b_mask[b]) sram_mem[b_addr][8*b +: 8] <= b_wdata[8*b +: 8];
    if (b_cs && !b_we) sram_rd_data <= sram_mem[b_addr];
    else               sram_rd_data <= $urandom;
    if (b3_rd) s3_sram_rd_data <= {8'hA5, 16'h0, b3_addr};
    else       s3_sram_rd_data <= $urandom;
  end

  // Scoreboard: expected read data in request order, tagged with its accept cycle.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  int          stamp_q [$];
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
    end else begin
      if (s_pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
      if (s_acc) begin
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_mask[b]) ref_mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
        end else begin
          exp_q.push_back(ref_mem[s_addr]);
          stamp_q.push_back(cyc);
        end
      end
      cyc <= cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] m,
                       input logic [7:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 8'h33, 32'h0000_1234);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %0b expected 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    n_cmp++; if ({sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !== 46'h0) begin
      n_err++; $display("FAIL reset_sram_bus: got cs=%0b addr=%h expected all zero", sram_cs, sram_addr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %0b expected 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %0b expected 0", rsp_valid); end
    tick();
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    // Full-word write then read back
    drive(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++; if ({sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !== {1'b1, 1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL wr_bus: got cs=%0b we=%0b m=%h a=%h d=%h expected 1 1 f 10 deadbeef",
                        sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data); end
    tick();
    drive(1'b1, 1'b0, 4'hF, 8'h10, 32'h5555_5555);
    @(negedge clk);
    n_cmp++; if ({sram_cs, sram_we, sram_wmask, sram_addr} !== {1'b1, 1'b0, 4'h0, 8'h10}) begin
      n_err++; $display("FAIL rd_bus: got cs=%0b we=%0b m=%h a=%h expected 1 0 0 10", sram_cs, sram_we, sram_wmask, sram_addr); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL write_no_rsp: got %0b expected 0", rsp_valid); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_latency1: got %0b expected 0", rsp_valid); end
    n_cmp++; if ({sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !== 46'h0) begin
      n_err++; $display("FAIL idle_bus: got cs=%0b addr=%h expected all zero", sram_cs, sram_addr); end
    tick();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL rd_full: got v=%0b d=%h expected 1 deadbeef", rsp_valid, rsp_rdata); end
    tick();
    // Partial write over the old word
    drive(1'b1, 1'b1, 4'h3, 8'h10, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    @(negedge clk);
    n_cmp++; if (sram_wmask !== 4'h0) begin n_err++; $display("FAIL rd_wmask: got %h expected 0", sram_wmask); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_5678) begin
      n_err++; $display("FAIL rd_partial: got v=%0b d=%h expected 1 dead5678", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] d [3];
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      drive(1'b1, 1'b1, 4'hF, 8'(8'h20 + i), d[i]);
      tick();
    end
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept0: got %0b expected 1", req_ready); end
    tick();
    drive(1'b1, 1'b0, 4'h0, 8'h21, 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept1: got %0b expected 1", req_ready); end
    tick();
    drive(1'b1, 1'b0, 4'h0, 8'h22, 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0 || sram_cs !== 1'b0) begin
      n_err++; $display("FAIL bp_third_blocked: got rdy=%0b cs=%0b expected 0 0", req_ready, sram_cs); end
    tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== d[0]) begin
        n_err++; $display("FAIL bp_hold: got rdy=%0b v=%0b d=%h expected 0 1 %h", req_ready, rsp_valid, rsp_rdata, d[0]); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0 || rsp_rdata !== d[0]) begin
      n_err++; $display("FAIL bp_pop_credit: got rdy=%0b d=%h expected 0 %h", req_ready, rsp_rdata, d[0]); end
    tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== d[1]) begin
      n_err++; $display("FAIL bp_third_accept: got rdy=%0b v=%0b d=%h expected 1 1 %h", req_ready, rsp_valid, rsp_rdata, d[1]); end
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_gap: got %0b expected 0", rsp_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== d[2]) begin
      n_err++; $display("FAIL bp_third_data: got v=%0b d=%h expected 1 %h", rsp_valid, rsp_rdata, d[2]); end
    tick();
  endtask

  task automatic test_stream();
    logic expv;
    s3_rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s3_req_valid = (c < 16);
      s3_req_addr  = 8'(c);
      @(negedge clk);
      if (c < 16) begin
        n_cmp++; if (s3_req_ready !== 1'b1 || s3_sram_cs !== 1'b1) begin
          n_err++; $display("FAIL stream_accept[%0d]: got rdy=%0b cs=%0b expected 1 1", c, s3_req_ready, s3_sram_cs); end
      end
      expv = (c >= 2 && c < 18);
      n_cmp++; if (s3_rsp_valid !== expv) begin
        n_err++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", c, s3_rsp_valid, expv); end
      if (expv) begin
        n_cmp++; if (s3_rsp_rdata !== {8'hA5, 16'h0, 8'(c - 2)}) begin
          n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", c, s3_rsp_rdata, {8'hA5, 16'h0, 8'(c - 2)}); end
      end
      tick();
    end
    s3_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_accept: got %0b expected 1", req_ready); end
    tick();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 8'h11, 32'h0);
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !== 80'h0) begin
      n_err++; $display("FAIL mid_reset_outputs: got rdy=%0b v=%0b d=%h cs=%0b expected all zero",
                        req_ready, rsp_valid, rsp_rdata, sram_cs); end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale[%0d]: got %0b expected 0", c, rsp_valid); end
      tick();
    end
    drive(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_5678) begin
      n_err++; $display("FAIL mid_new_read: got v=%0b d=%h expected 1 dead5678", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_random();
    int   ops = 0;
    int   cycles = 0;
    logic rexp, vexp, cexp;
    while (ops < 10000 && cycles < 40000) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, 4'($urandom),
            8'($urandom_range(0, 15)), $urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      rexp = (exp_q.size() < DEPTH);
      vexp = (exp_q.size() > 0) && (stamp_q[0] + 2 <= cyc);
      cexp = req_valid && rexp;
      n_cmp++; if (req_ready !== rexp) begin
        n_err++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", cycles, req_ready, rexp); end
      n_cmp++; if (rsp_valid !== vexp) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", cycles, rsp_valid, vexp); end
      if (vexp) begin
        n_cmp++; if (rsp_rdata !== exp_q[0]) begin
          n_err++; $display("FAIL rnd_data@%0d: got %h expected %h", cycles, rsp_rdata, exp_q[0]); end
      end
      n_cmp++;
      if (cexp) begin
        if ({sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !==
            {1'b1, req_we, req_we ? req_wmask : 4'h0, req_addr, req_wdata}) begin
          n_err++; $display("FAIL rnd_bus@%0d: got cs=%0b we=%0b m=%h a=%h expected 1 %0b %h %h",
                            cycles, sram_cs, sram_we, sram_wmask, sram_addr, req_we, req_we ? req_wmask : 4'h0, req_addr); end
      end else if ({sram_cs, sram_we, sram_wmask, sram_addr, sram_wr_data} !== 46'h0) begin
        n_err++; $display("FAIL rnd_bus_idle@%0d: got cs=%0b a=%h expected all zero", cycles, sram_cs, sram_addr);
      end
      n_cmp++; if (dut.count > DEPTH) begin
        n_err++; $display("FAIL rnd_count@%0d: got %0d expected <= %0d", cycles, dut.count, DEPTH); end
      if (req_valid && req_ready) ops++;
      cycles++;
      tick();
    end
    n_cmp++; if (ops < 10000) begin n_err++; $display("FAIL rnd_ops: got %0d expected 10000 within budget", ops); end
    drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    test_reset();
    test_write_read();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
